ptw_mem_responder: RTL

//  Responder end of the page-table-walk memory interface: accepts 64-bit PTE read requests from the Sv39 MMU walker,

---
 rtl/mmu_pkg.sv | 26 ++
 rtl/ptw_rsp_fifo.sv | 58 +++++
 rtl/ptw_mem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - Sv39 PTE field indices and page constants shared with the MMU walker
package mmu_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 53;

    localparam logic [3:0] SATP_MODE_SV39 = 4'b1000;
    localparam int PAGE_OFFSET_W = 12;
    localparam int VPN_W         = 9;
    localparam int PTE_BYTES     = 8;

    // A valid leaf (readable or executable) whose accessed bit is still clear
    function automatic logic pte_a_settable(input logic [63:0] pte);
        return pte[PTE_V] && !pte[PTE_A] && (pte[PTE_R] || pte[PTE_X]);
    endfunction

endpackage

// File: rtl/ptw_rsp_fifo.sv
// rtl/ptw_rsp_fifo.sv - synchronous response FIFO carrying {fault,id,pte} with occupancy count
module ptw_rsp_fifo #(
    parameter int RSP_DEPTH = 2,
    parameter int W         = 67
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_valid,
    input  logic [W-1:0]                       wr_data,
    input  logic                               rd_ready,
    output logic                               rd_valid,
    output logic [W-1:0]                       rd_data,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RSP_DEPTH);

    logic [W-1:0]     mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign push     = wr_valid && ((count != FULL) || pop);
    assign rd_data  = mem[rd_ptr];

    // Storage, wrap-around pointers and occupancy; storage cleared so the head reads zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ptw_mem_responder.sv
// rtl/ptw_mem_responder.sv - PTE read responder over a sync page-table RAM; optional PTW_A_UPDATE_EN
module ptw_mem_responder
    import mmu_pkg::*;
#(
    parameter int IDX_W     = 9,
    parameter int PA_W      = 56,
    parameter int ID_W      = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [PA_W-1:0] req_addr,
    input  logic [ID_W-1:0] req_id,
    input  logic            req_set_a,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [63:0]     rsp_pte,
    output logic [ID_W-1:0] rsp_id,
    output logic            rsp_fault,
    input  logic            cfg_we,
    input  logic [PA_W-1:0] cfg_addr,
    input  logic [63:0]     cfg_wdata
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PL_W  = 1 + ID_W + 64;

    logic [63:0]      ram [DEPTH];
    logic [63:0]      rd_data;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] cfg_idx;
    logic             req_fault;
    logic             cfg_ok;
    logic             req_fire;
    logic             rsp_fire;
    logic             wb_block;

    logic             ram_we;
    logic [IDX_W-1:0] ram_widx;
    logic [63:0]      ram_wdata;

    logic             s1_valid;
    logic             s1_fault;
    logic [ID_W-1:0]  s1_id;
    logic [63:0]      s1_pte;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ;
    logic [CNT_W:0]   lim;

    assign req_idx   = req_addr[IDX_W+2:3];
    assign req_fault = (req_addr[2:0] != 3'd0) || (req_addr[PA_W-1:IDX_W+3] != '0);
    assign cfg_idx   = cfg_addr[IDX_W+2:3];
    assign cfg_ok    = cfg_we && (cfg_addr[2:0] == 3'd0) && (cfg_addr[PA_W-1:IDX_W+3] == '0);

    assign rsp_fire  = rsp_valid && rsp_ready;
    assign req_fire  = req_valid && req_ready;

    // Accept only while the FIFO plus the in-flight read still fit after this cycle's dequeue
    assign occ       = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid);
    assign lim       = (CNT_W+1)'(RSP_DEPTH) + (CNT_W+1)'(rsp_fire);
    assign req_ready = !wb_block && (occ < lim);

`ifdef PTW_A_UPDATE_EN
    logic             s1_set_a;
    logic [IDX_W-1:0] s1_idx;
    logic             set_now;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [63:0]      wb_data;

    assign set_now  = s1_valid && s1_set_a && !s1_fault && pte_a_settable(rd_data);
    assign wb_block = wb_valid;

    // Capture the A-bit writeback issued the cycle after the leaf is read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= set_now;
            wb_idx   <= s1_idx;
            wb_data  <= s1_pte;
        end
    end

    // Extra S1 context needed to locate and qualify the writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_set_a <= 1'b0;
            s1_idx   <= '0;
        end else if (req_fire) begin
            s1_set_a <= req_set_a;
            s1_idx   <= req_idx;
        end
    end

    // Single write port: preload wins, a colliding writeback is dropped
    always_comb begin
        ram_we    = cfg_ok;
        ram_widx  = cfg_idx;
        ram_wdata = cfg_wdata;
        if (!cfg_ok && wb_valid) begin
            ram_we    = 1'b1;
            ram_widx  = wb_idx;
            ram_wdata = wb_data;
        end
    end

    // Fault responses carry zero data; eligible leaves return with A set
    always_comb begin
        s1_pte = s1_fault ? 64'd0 : rd_data;
        if (set_now) begin
            s1_pte[PTE_A] = 1'b1;
        end
    end
`else
    logic unused_set_a;

    assign unused_set_a = req_set_a;
    assign wb_block     = 1'b0;

    // Only the preload port writes the RAM
    always_comb begin
        ram_we    = cfg_ok;
        ram_widx  = cfg_idx;
        ram_wdata = cfg_wdata;
    end

    // Fault responses carry zero data
    always_comb begin
        s1_pte = s1_fault ? 64'd0 : rd_data;
    end
`endif

    // Page-table RAM: one write port, one registered read port returning pre-write data
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_widx] <= ram_wdata;
        end
        if (req_fire && !req_fault) begin
            rd_data <= ram[req_idx];
        end
    end

    // S1 holds the tag and fault status alongside the RAM read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_fault <= 1'b0;
            s1_id    <= '0;
        end else begin
            s1_valid <= req_fire;
            if (req_fire) begin
                s1_fault <= req_fault;
                s1_id    <= req_id;
            end
        end
    end

    ptw_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH),
        .W         (PL_W)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (s1_valid),
        .wr_data  ({s1_fault, s1_id, s1_pte}),
        .rd_ready (rsp_ready),
        .rd_valid (rsp_valid),
        .rd_data  ({rsp_fault, rsp_id, rsp_pte}),
        .count    (fifo_count)
    );

endmodule
